// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient loader.
// Holds the default coefficient width and the loader FSM state type.
package fir_pkg;

   localparam int COEFF_W_DEF = 16;
   localparam int N_TAPS_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      PENDING = 2'd2
   } coeff_ld_state_t;

endpackage

// File: rtl/fir_coeff_loader.sv
// Coefficient loader: streams a signed set into a shadow bank and
// commits it to the active bank that feeds all MAC taps on swap_en.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   s_valid/s_ready/s_data  coefficient stream handshake (word 0 = tap 0)
//   s_last                  marks the final word of a set (word N_TAPS-1)
//   swap_en                 sample-boundary strobe, commits a pending set
//   coeff_out               active bank, tap k at [k*COEFF_W +: COEFF_W]
//   bank_pending            full set waiting in the shadow bank
//   load_err                one-cycle pulse when a malformed set is dropped
module fir_coeff_loader
   import fir_pkg::*;
#(
   parameter int COEFF_W = COEFF_W_DEF,
   parameter int N_TAPS  = N_TAPS_DEF
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [COEFF_W-1:0]        s_data,
   input  logic                      s_last,
   input  logic                      swap_en,
   output logic [N_TAPS*COEFF_W-1:0] coeff_out,
   output logic                      bank_pending,
   output logic                      load_err
);

   localparam int CW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N_TAPS - 1);

   coeff_ld_state_t r_state;
   coeff_ld_state_t w_state_nxt;

   logic [CW-1:0]      r_cnt;
   logic [CW-1:0]      w_cnt_nxt;
   logic               r_err;
   logic               w_err;
   logic               w_wr;
   logic               w_swap;
   logic               w_ready;
   logic               w_last_slot;

   logic [COEFF_W-1:0] r_shadow [N_TAPS];
   logic [COEFF_W-1:0] r_active [N_TAPS];

   assign w_last_slot  = (r_cnt == LAST_IDX);
   assign s_ready      = w_ready;
   assign bank_pending = (r_state == PENDING);
   assign load_err     = r_err;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_err;
      end
   end

   // Next-state and control decode. In IDLE/LOAD the loader is always
   // ready, so s_valid alone qualifies a transfer there.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_err       = 1'b0;
      w_wr        = 1'b0;
      w_swap      = 1'b0;
      w_ready     = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (s_valid) begin
               w_wr = 1'b1;
               if (s_last) begin
                  w_err     = 1'b1;
                  w_cnt_nxt = '0;
               end else begin
                  w_state_nxt = LOAD;
                  w_cnt_nxt   = CW'(1);
               end
            end
         end
         LOAD: begin
            w_ready = 1'b1;
            if (s_valid) begin
               w_wr = 1'b1;
               if (s_last && w_last_slot) begin
                  w_state_nxt = PENDING;
                  w_cnt_nxt   = '0;
               end else if (s_last || w_last_slot) begin
                  // Too short, or full without a terminator
                  w_err       = 1'b1;
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
         end
         PENDING: begin
            if (swap_en) begin
               w_swap      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Shadow bank: written at the running word index
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N_TAPS; k++) begin
            r_shadow[k] <= '0;
         end
      end else if (w_wr) begin
         r_shadow[r_cnt] <= s_data;
      end
   end

   // Active bank: whole-set commit so taps never see a partial set
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N_TAPS; k++) begin
            r_active[k] <= '0;
         end
      end else if (w_swap) begin
         for (int k = 0; k < N_TAPS; k++) begin
            r_active[k] <= r_shadow[k];
         end
      end
   end

   for (genvar g = 0; g < N_TAPS; g++) begin : g_tap
      assign coeff_out[g*COEFF_W +: COEFF_W] = r_active[g];
   end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader.
// Directed and random steps against a queue-based set model.
module tb_fir_coeff_loader;

   localparam int W = 16;
   localparam int N = 8;

   logic           clock;
   logic           reset;
   logic           s_valid;
   logic           s_ready;
   logic [W-1:0]   s_data;
   logic           s_last;
   logic           swap_en;
   logic [N*W-1:0] coeff_out;
   logic           bank_pending;
   logic           load_err;

   int checks = 0;
   int errors = 0;

   // Reference model: words of the set in progress, committed bank,
   // whether a full set is waiting, and whether an error just occurred.
   logic [W-1:0] m_q[$];
   logic [W-1:0] m_active [N];
   logic [W-1:0] m_pend [N];
   bit           m_pending;
   bit           m_err;

   fir_coeff_loader #(.COEFF_W(W), .N_TAPS(N)) dut (
      .clock        (clock),
      .reset        (reset),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_last       (s_last),
      .swap_en      (swap_en),
      .coeff_out    (coeff_out),
      .bank_pending (bank_pending),
      .load_err     (load_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [N*W-1:0] exp_bank();
      logic [N*W-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[k*W +: W] = m_active[k];
      return v;
   endfunction

   task automatic chk(input string tag, input logic [N*W-1:0] obs,
                      input logic [N*W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".ready"}, {{(N*W-1){1'b0}}, s_ready},
          {{(N*W-1){1'b0}}, !m_pending});
      chk({tag, ".pend"}, {{(N*W-1){1'b0}}, bank_pending},
          {{(N*W-1){1'b0}}, m_pending});
      chk({tag, ".err"}, {{(N*W-1){1'b0}}, load_err},
          {{(N*W-1){1'b0}}, m_err});
      chk({tag, ".coeff"}, coeff_out, exp_bank());
   endtask

   task automatic model_reset();
      m_q.delete();
      for (int k = 0; k < N; k++) begin
         m_active[k] = '0;
         m_pend[k]   = '0;
      end
      m_pending = 0;
      m_err     = 0;
   endtask

   // One clock: drive inputs, advance, update model, check all outputs.
   task automatic cycle(input string tag, input bit v, input logic [W-1:0] d,
                        input bit l, input bit sw);
      bit acc;
      s_valid = v;
      s_data  = d;
      s_last  = l;
      swap_en = sw;
      acc     = v && !m_pending;
      @(posedge clock);
      #1;
      m_err = 0;
      if (m_pending) begin
         if (sw) begin
            for (int k = 0; k < N; k++) m_active[k] = m_pend[k];
            m_pending = 0;
         end
      end else if (acc) begin
         m_q.push_back(d);
         if (l) begin
            if (m_q.size() == N) begin
               for (int k = 0; k < N; k++) m_pend[k] = m_q[k];
               m_pending = 1;
            end else begin
               m_err = 1;
            end
            m_q.delete();
         end else if (m_q.size() == N) begin
            m_err = 1;
            m_q.delete();
         end
      end
      chk_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag, 0, '0, 0, 0);
   endtask

   initial begin
      logic [W-1:0] d;
      bit           l;
      s_valid = 0;
      s_data  = '0;
      s_last  = 0;
      swap_en = 0;
      reset   = 1;
      model_reset();
      #12;
      chk_all("reset");
      reset = 0;

      // Idle, swap_en ignored while nothing is pending
      idle("idle", 2);
      cycle("idle_swap", 0, '0, 0, 1);

      // 1..8 back-to-back, swap 3 cycles after the last word
      for (int i = 0; i < N; i++)
         cycle("ramp", 1, W'(i + 1), i == N - 1, 0);
      idle("ramp_wait", 2);
      chk("ramp_old_zero", coeff_out, '0);
      cycle("ramp_swap", 0, '0, 0, 1);
      chk("ramp_tap0", {{(N*W-W){1'b0}}, coeff_out[0 +: W]}, 1);
      chk("ramp_tap7", {{(N*W-W){1'b0}}, coeff_out[7*W +: W]}, 8);
      idle("ramp_after", 1);

      // -1..-8 with a gap every other cycle
      for (int i = 0; i < N; i++) begin
         cycle("neg", 1, W'(-(i + 1)), i == N - 1, 0);
         if (i != N - 1) cycle("neg_gap", 0, W'($urandom), 0, 0);
      end
      cycle("neg_swap", 0, '0, 0, 1);
      chk("neg_tap7", {{(N*W-W){1'b0}}, coeff_out[7*W +: W]}, 16'hFFF8);

      // Short set: s_last on the 5th word
      for (int i = 0; i < 5; i++)
         cycle("short", 1, W'($urandom), i == 4, 0);
      idle("short_after", 1);
      for (int i = 0; i < N; i++)
         cycle("good", 1, W'($urandom), i == N - 1, 0);
      cycle("good_swap", 0, '0, 0, 1);

      // Eight words with no s_last, then a swap that must not commit
      for (int i = 0; i < N; i++)
         cycle("nolast", 1, W'($urandom), 0, 0);
      cycle("nolast_swap", 0, '0, 0, 1);
      idle("nolast_after", 1);

      // Last word coincides with swap_en: no commit until the next strobe
      for (int i = 0; i < N; i++)
         cycle("coinc", 1, W'($urandom), i == N - 1, i == N - 1);
      cycle("coinc_blocked", 1, W'($urandom), 1, 0);
      cycle("coinc_swap", 0, '0, 0, 1);

      // Reset while a set is pending
      for (int i = 0; i < N; i++)
         cycle("rpend", 1, W'($urandom), i == N - 1, 0);
      #2;
      reset = 1;
      #1;
      model_reset();
      chk_all("rst_pend");
      @(negedge clock);
      reset = 0;
      idle("rst_after", 1);

      // Random traffic, mostly well-formed sets
      for (int i = 0; i < 400; i++) begin
         d = W'($urandom);
         if (m_q.size() == N - 1) l = ($urandom % 8) != 0;
         else                     l = ($urandom % 24) == 0;
         cycle("rand", ($urandom % 4) != 0, d, l, ($urandom % 3) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
